// File: rtl/imem_loadable_fetch_if.sv
// Load and fetch port bundle for the loadable instruction memory.
interface imem_loadable_fetch_if #(
  parameter int unsigned INS_ADDRESS = 9,
  parameter int unsigned INS_W       = 32,
  parameter int unsigned PC_W        = 32
);
  // Program-load port
  logic                   ld_start;
  logic [INS_ADDRESS-3:0] ld_base;
  logic                   ld_valid;
  logic [INS_W-1:0]       ld_data;
  logic                   ld_last;
  logic                   ld_ready;
  logic                   ld_busy;
  logic [INS_ADDRESS-2:0] ld_count;
  logic                   ld_wrap;

  // Fetch port
  logic                   req_valid;
  logic [PC_W-1:0]        req_addr;
  logic                   req_ready;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [INS_W-1:0]       resp_data;
  logic                   resp_err;

  modport master (
    output ld_start, ld_base, ld_valid, ld_data, ld_last,
    output req_valid, req_addr, resp_ready,
    input  ld_ready, ld_busy, ld_count, ld_wrap,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  ld_start, ld_base, ld_valid, ld_data, ld_last,
    input  req_valid, req_addr, resp_ready,
    output ld_ready, ld_busy, ld_count, ld_wrap,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/imem_loadable_fetch.sv
// Run-time loadable instruction memory: sequential load port plus
// handshaked fetch port with one-cycle registered read and fault detection.
module imem_loadable_fetch #(
  parameter int unsigned      INS_ADDRESS = 9,
  parameter int unsigned      INS_W       = 32,
  parameter int unsigned      PC_W        = 32,
  parameter logic [INS_W-1:0] NOP_INSTR   = 32'h0000_0013
) (
  input logic                 clk,
  input logic                 reset,
  imem_loadable_fetch_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** (INS_ADDRESS - 2);
  localparam int unsigned IDX_W = INS_ADDRESS - 2;
  localparam int unsigned CNT_W = INS_ADDRESS - 1;

  localparam logic [PC_W-1:0]  ADDR_LIMIT = PC_W'(4 * DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [INS_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0] ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             wrap_q;

  logic             resp_valid_q;
  logic [INS_W-1:0] resp_data_q;
  logic             resp_err_q;

  logic ld_ready_c;
  logic req_ready_c;
  logic ld_wr_c;
  logic req_fire_c;
  logic fault_c;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake readies; load start wins over a fetch
  always_comb begin
    state_d     = state_q;
    ld_ready_c  = 1'b0;
    req_ready_c = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_c = !bus.ld_start && (!resp_valid_q || bus.resp_ready);
        if (bus.ld_start) state_d = LOAD;
      end
      LOAD: begin
        ld_ready_c = 1'b1;
        if (bus.ld_valid && bus.ld_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ld_wr_c    = ld_ready_c && bus.ld_valid;
  assign req_fire_c = bus.req_valid && req_ready_c;
  assign fault_c    = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr >= ADDR_LIMIT);

  // Memory write; contents survive reset, but a reset cycle never writes
  always_ff @(posedge clk) begin
    if (!reset && ld_wr_c) mem[ptr_q] <= bus.ld_data;
  end

  // Burst write pointer, saturating word count and sticky wrap flag
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else if (state_q == IDLE && bus.ld_start) begin
      ptr_q   <= bus.ld_base;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else if (ld_wr_c) begin
      ptr_q <= ptr_q + IDX_W'(1);
      if (count_q != CNT_MAX) count_q <= count_q + CNT_W'(1);
      if (ptr_q == IDX_LAST)  wrap_q  <= 1'b1;
    end
  end

  // Registered fetch response, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else if (req_fire_c) begin
      resp_valid_q <= 1'b1;
      resp_data_q  <= fault_c ? NOP_INSTR : mem[bus.req_addr[INS_ADDRESS-1:2]];
      resp_err_q   <= fault_c;
    end else if (bus.resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign bus.ld_ready   = ld_ready_c;
  assign bus.ld_busy    = (state_q == LOAD);
  assign bus.ld_count   = count_q;
  assign bus.ld_wrap    = wrap_q;
  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: doc/imem_loadable_fetch.md
Name: imem_loadable_fetch

Overview:
Parameterised instruction memory with two ports: a handshaked fetch port, with one-cycle registered read latency and fault detection, and a sequential program-load port driven by a small state machine. It replaces the preloaded combinational instruction ROM feeding the PC/decode path. Programs are streamed in at run time by the testbench or a boot loader, with no initial-block contents.

Parameters:
INS_ADDRESS, 9, byte-address bits covering the memory; depth DEPTH = 2**(INS_ADDRESS-2) words (128 by default)
INS_W, 32, instruction word width
PC_W, 32, width of the fetch address (byte address from PC)
NOP_INSTR, 32'h00000013, word returned on a faulted fetch (addi x0,x0,0)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
ld_start  in  1  pulse: begin a load burst at ld_base
ld_base  in  INS_ADDRESS-2  starting word index of the burst
ld_valid  in  1  load word valid
ld_data  in  INS_W  load word
ld_last  in  1  marks the final word of the burst (qualified by ld_valid & ld_ready)
ld_ready  out  1  load word accepted this cycle when ld_valid high
ld_busy  out  1  high while in LOAD
ld_count  out  INS_ADDRESS-1  words written in the current or most recent burst, saturating
ld_wrap  out  1  sticky: write pointer wrapped past DEPTH-1 during the current or most recent burst
req_valid  in  1  fetch request
req_addr  in  PC_W  fetch byte address
req_ready  out  1  fetch request accepted when req_valid high
resp_valid  out  1  fetch response valid
resp_ready  in  1  consumer accepts response
resp_data  out  INS_W  fetched instruction
resp_err  out  1  fault flag for resp_data

Behaviour:
- Reset (synchronous, active-high): state=IDLE; resp_valid=0, resp_data=0, resp_err=0, ld_busy=0, ld_count=0, ld_wrap=0. Memory contents are not cleared. Reset mid-burst aborts the burst; words already written persist.
- States: IDLE and LOAD.
- IDLE -> LOAD when ld_start=1:
  - write pointer <= ld_base, ld_count <= 0, ld_wrap <= 0.
  - ld_start takes priority over a same-cycle req_valid: req_ready=0 in that cycle.
  - ld_start in LOAD is ignored.
- LOAD:
  - ld_ready=1, req_ready=0.
  - Each cycle with ld_valid=1 writes mem[ptr] <= ld_data, increments ptr, and increments ld_count (saturating at 2**(INS_ADDRESS-1)-1).
  - ptr wraps from DEPTH-1 to 0 and sets ld_wrap.
  - ld_valid & ld_last writes the word, then goes LOAD -> IDLE.
  - ld_valid=0 cycles stall with no write.
  - In IDLE, ld_ready=0 and ld_valid is ignored.
- Fetch handshake:
  - req_ready = (state==IDLE) & !ld_start & (!resp_valid | resp_ready).
  - An accepted request produces resp_valid=1 on the next cycle, with resp_data/resp_err registered (latency 1).
  - A response is held stable while resp_valid & !resp_ready.
  - resp_valid drops after acceptance unless a new request is accepted in the same cycle; back-to-back fetches give one response per cycle.
  - A response pending at the IDLE -> LOAD transition still drains normally.
- Fault rules:
  - resp_err=1 and resp_data=NOP_INSTR if req_addr[1:0]!=0 (misaligned) or req_addr >= 4*DEPTH (out of range; compare the full PC_W width).
  - Otherwise resp_data = mem[req_addr[INS_ADDRESS-1:2]] and resp_err=0.
- Load and fetch are mutually exclusive, so there is no read/write collision. Reading a never-written word returns X in simulation; a bench must not check it.

Test Plan:
- Reset, then ld_start with ld_base=0, and 4 words 00100093, 00200113, 00308193, 00208433 with ld_last on the 4th -> ld_busy high for 4 cycles; ld_count=4; ld_wrap=0; back in IDLE.
- Fetch addresses 0x0, 0x4, 0x8, 0xC back-to-back with resp_ready=1 -> responses one cycle after each request, in order, with those four words; resp_err=0; req_ready stays 1.
- Fetch 0x6 (misaligned), then 0x200 (out of range, DEPTH=128) -> resp_err=1 and resp_data=00000013 for both.
- Hold resp_ready=0 for 3 cycles after a fetch of 0x4 -> resp_data stays 00200113 and req_ready=0 throughout; after resp_ready=1 the next request is accepted.
- ld_base=127, load 3 words with ld_valid gaps -> words land at indices 127, 0, 1; ld_wrap=1; ld_count=3; fetches of 0x1FC, 0x0, 0x4 return them.
- Assert reset after 2 of 5 burst words -> state IDLE; ld_busy=0; resp_valid=0; a fetch returns the 2 written words and ld_ready=0.
